seq_detector: RTL and testbench

SEQ_DETECTOR -- requirements
Module: seq_detector

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/seq_det_cnt.sv | 29 ++
 rtl/seq_detector.sv | 111 +++++++++++
 tb/tb_seq_detector.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and default sizing for the step-sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_DEPTH = 3;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/seq_det_cnt.sv
// Saturating match counter; clear beats a coincident increment, reset beats both.
module seq_det_cnt #(
    parameter int CNT_W = seq_det_pkg::DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_sat;

    assign w_sat = &r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detector.sv
// Overlapping multi-step masked pattern detector with IDLE/ARMED/DONE control.
// Every hit on step 0 launches a new attempt; match is registered alongside the last step.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   one_shot,
    input  logic                   valid,
    input  logic [WIDTH-1:0]       sig_in,
    input  logic [DEPTH*WIDTH-1:0] step_val,
    input  logic [DEPTH*WIDTH-1:0] step_mask,
    input  logic                   clr_cnt,
    output logic                   match,
    output logic [DEPTH-1:0]       active,
    output logic [CNT_W-1:0]       match_cnt,
    output logic [1:0]             state
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DEPTH-1:0] r_p;
    logic [DEPTH-1:0] w_hit;
    logic [DEPTH-1:0] w_p_nxt;
    logic             r_match;
    logic             w_armed;
    logic             w_match_nxt;

    always_comb begin
        w_hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_hit[k] = ((sig_in ^ step_val[k*WIDTH +: WIDTH])
                        & step_mask[k*WIDTH +: WIDTH]) == '0;
        end
    end

    always_comb begin
        w_p_nxt    = '0;
        w_p_nxt[0] = w_hit[0];
        for (int k = 1; k < DEPTH; k++) begin
            w_p_nxt[k] = r_p[k-1] & w_hit[k];
        end
    end

    assign w_armed = (r_state == ARMED);
    // A stop on the completing edge discards the attempt; only the DONE exit keeps its pulse.
    assign w_match_nxt = w_armed && valid && !stop && w_p_nxt[DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start && !stop) w_state_nxt = ARMED;
            end
            ARMED: begin
                if (stop)                          w_state_nxt = IDLE;
                else if (one_shot && w_match_nxt)  w_state_nxt = DONE;
            end
            DONE: begin
                if (stop)       w_state_nxt = IDLE;
                else if (start) w_state_nxt = ARMED;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p     <= '0;
            r_match <= 1'b0;
        end else begin
            r_match <= w_match_nxt;
            if (!w_armed || (w_state_nxt != ARMED)) begin
                r_p <= '0;
            end else if (valid) begin
                r_p <= w_p_nxt;
            end
        end
    end

    always_comb begin
        match  = r_match;
        active = r_p;
        state  = r_state;
    end

    seq_det_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (clr_cnt),
        .i_inc (r_match),
        .o_cnt (match_cnt)
    );

endmodule

// File: tb/tb_seq_detector.sv
// Directed vector bench for seq_detector: steps a/b/c on sig_in = {c,b,a}.
module tb_seq_detector;

    localparam int W = 3;
    localparam int D = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, stop, one_shot, valid, clr_cnt;
    logic [W-1:0] sig_in;
    logic [D*W-1:0] step_val  = 9'b100_010_001;
    logic [D*W-1:0] step_mask = 9'b100_010_001;

    logic         match,  match2;
    logic [D-1:0] active, active2;
    logic [7:0]   match_cnt;
    logic [1:0]   match_cnt2;
    logic [1:0]   state,  state2;

    int n_chk  = 0;
    int n_fail = 0;

    seq_detector #(.WIDTH(W), .DEPTH(D), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .one_shot(one_shot),
        .valid(valid), .sig_in(sig_in), .step_val(step_val), .step_mask(step_mask),
        .clr_cnt(clr_cnt), .match(match), .active(active), .match_cnt(match_cnt),
        .state(state)
    );

    seq_detector #(.WIDTH(W), .DEPTH(D), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .one_shot(one_shot),
        .valid(valid), .sig_in(sig_in), .step_val(step_val), .step_mask(step_mask),
        .clr_cnt(clr_cnt), .match(match2), .active(active2), .match_cnt(match_cnt2),
        .state(state2)
    );

    // ctl = {rst, start, stop, one_shot, valid, clr_cnt}; expectations hold just after the edge.
    typedef struct {
        logic [5:0] ctl;
        logic [2:0] sig;
        logic       m;
        logic [2:0] act;
        logic [7:0] cnt;
        logic [1:0] st;
    } vec_t;

    localparam int NV = 33;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drv(input logic [5:0] ctl, input logic [2:0] sig);
        {rst, start, stop, one_shot, valid, clr_cnt} = ctl;
        sig_in = sig;
        @(posedge clk);
        #1;
    endtask

    initial begin
        {rst, start, stop, one_shot, valid, clr_cnt} = 6'b100010;
        sig_in = '0;

        tbl[0]  = '{6'b100010, 3'b000, 1'b0, 3'b000, 8'd0, 2'd0};
        tbl[1]  = '{6'b010010, 3'b000, 1'b0, 3'b000, 8'd0, 2'd1};
        tbl[2]  = '{6'b000010, 3'b001, 1'b0, 3'b001, 8'd0, 2'd1};
        tbl[3]  = '{6'b000010, 3'b010, 1'b0, 3'b010, 8'd0, 2'd1};
        tbl[4]  = '{6'b000010, 3'b100, 1'b1, 3'b100, 8'd0, 2'd1};
        tbl[5]  = '{6'b000010, 3'b000, 1'b0, 3'b000, 8'd1, 2'd1};
        tbl[6]  = '{6'b000011, 3'b111, 1'b0, 3'b001, 8'd0, 2'd1};
        tbl[7]  = '{6'b000010, 3'b111, 1'b0, 3'b011, 8'd0, 2'd1};
        tbl[8]  = '{6'b000010, 3'b111, 1'b1, 3'b111, 8'd0, 2'd1};
        tbl[9]  = '{6'b000010, 3'b111, 1'b1, 3'b111, 8'd1, 2'd1};
        tbl[10] = '{6'b000010, 3'b111, 1'b1, 3'b111, 8'd2, 2'd1};
        tbl[11] = '{6'b000010, 3'b000, 1'b0, 3'b000, 8'd3, 2'd1};
        tbl[12] = '{6'b000010, 3'b001, 1'b0, 3'b001, 8'd3, 2'd1};
        tbl[13] = '{6'b000010, 3'b011, 1'b0, 3'b011, 8'd3, 2'd1};
        tbl[14] = '{6'b000000, 3'b000, 1'b0, 3'b011, 8'd3, 2'd1};
        tbl[15] = '{6'b000000, 3'b111, 1'b0, 3'b011, 8'd3, 2'd1};
        tbl[16] = '{6'b000010, 3'b100, 1'b1, 3'b100, 8'd3, 2'd1};
        tbl[17] = '{6'b000010, 3'b000, 1'b0, 3'b000, 8'd4, 2'd1};
        tbl[18] = '{6'b011010, 3'b000, 1'b0, 3'b000, 8'd4, 2'd0};
        tbl[19] = '{6'b000010, 3'b001, 1'b0, 3'b000, 8'd4, 2'd0};
        tbl[20] = '{6'b010110, 3'b000, 1'b0, 3'b000, 8'd4, 2'd1};
        tbl[21] = '{6'b000110, 3'b001, 1'b0, 3'b001, 8'd4, 2'd1};
        tbl[22] = '{6'b000110, 3'b010, 1'b0, 3'b010, 8'd4, 2'd1};
        tbl[23] = '{6'b000110, 3'b100, 1'b1, 3'b000, 8'd4, 2'd2};
        tbl[24] = '{6'b000110, 3'b001, 1'b0, 3'b000, 8'd5, 2'd2};
        tbl[25] = '{6'b000110, 3'b010, 1'b0, 3'b000, 8'd5, 2'd2};
        tbl[26] = '{6'b000110, 3'b100, 1'b0, 3'b000, 8'd5, 2'd2};
        tbl[27] = '{6'b010110, 3'b000, 1'b0, 3'b000, 8'd5, 2'd1};
        tbl[28] = '{6'b000110, 3'b001, 1'b0, 3'b001, 8'd5, 2'd1};
        tbl[29] = '{6'b000110, 3'b010, 1'b0, 3'b010, 8'd5, 2'd1};
        tbl[30] = '{6'b000110, 3'b100, 1'b1, 3'b000, 8'd5, 2'd2};
        tbl[31] = '{6'b000110, 3'b000, 1'b0, 3'b000, 8'd6, 2'd2};
        tbl[32] = '{6'b001110, 3'b000, 1'b0, 3'b000, 8'd6, 2'd0};

        for (int i = 0; i < NV; i++) begin
            drv(tbl[i].ctl, tbl[i].sig);
            check($sformatf("v%0d.match", i),  {31'd0, match},  {31'd0, tbl[i].m});
            check($sformatf("v%0d.active", i), {29'd0, active}, {29'd0, tbl[i].act});
            check($sformatf("v%0d.cnt", i),    {24'd0, match_cnt}, {24'd0, tbl[i].cnt});
            check($sformatf("v%0d.state", i),  {30'd0, state},  {30'd0, tbl[i].st});
        end

        // Reset in the middle of an attempt, with start also high.
        drv(6'b010010, 3'b000);
        drv(6'b000010, 3'b001);
        drv(6'b000010, 3'b010);
        check("pre_rst.active", {29'd0, active}, 32'h2);
        check("pre_rst.cnt", {24'd0, match_cnt}, 32'd6);
        drv(6'b110010, 3'b100);
        check("rst.active", {29'd0, active}, 32'h0);
        check("rst.match", {31'd0, match}, 32'h0);
        check("rst.cnt", {24'd0, match_cnt}, 32'd0);
        check("rst.state", {30'd0, state}, 32'd0);
        drv(6'b000010, 3'b100);
        check("post_rst_c.match", {31'd0, match}, 32'h0);
        check("post_rst_c.state", {30'd0, state}, 32'd0);

        // After arming, the first match needs DEPTH full edges.
        drv(6'b010010, 3'b111);
        drv(6'b000010, 3'b111);
        check("arm_e1.match", {31'd0, match}, 32'h0);
        drv(6'b000010, 3'b111);
        check("arm_e2.match", {31'd0, match}, 32'h0);
        drv(6'b000010, 3'b111);
        check("arm_e3.match", {31'd0, match}, 32'h1);

        // 2-bit counter saturation, then clear coincident with a match pulse.
        drv(6'b100010, 3'b000);
        drv(6'b010010, 3'b000);
        for (int e = 1; e <= 6; e++) drv(6'b000010, 3'b111);
        check("sat_e6.cnt2", {30'd0, match_cnt2}, 32'd3);
        drv(6'b000010, 3'b111);
        check("sat_e7.cnt2", {30'd0, match_cnt2}, 32'd3);
        check("sat_e7.match2", {31'd0, match2}, 32'h1);
        check("sat_e7.cnt8", {24'd0, match_cnt}, 32'd4);
        drv(6'b000011, 3'b111);
        check("clr.cnt2", {30'd0, match_cnt2}, 32'd0);
        check("clr.cnt8", {24'd0, match_cnt}, 32'd0);
        check("clr.match2", {31'd0, match2}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
